axi_lite_master: RTL

AXI_LITE_MASTER -- requirements
Module: axi_lite_master

---
 rtl/axi_lite_master.sv | 210 +++++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator driven by a valid/ready command and response pair.
// Optional misaligned-address rejection is compiled in by defining AXIL_MASTER_ALIGN_CHK_EN.
module axi_lite_master #(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_REQ  = 3'd1,
    WR_RESP = 3'd2,
    RD_REQ  = 3'd3,
    RD_DATA = 3'd4,
    RSP     = 3'd5
  } state_t;

  state_t                state_r, state_s;
  logic                  aw_done_r, aw_done_s;
  logic                  w_done_r, w_done_s;
  logic [ADDR_WIDTH-1:0] addr_r, addr_s;
  logic [DATA_WIDTH-1:0] wdata_r, wdata_s;
  logic                  rsp_write_r, rsp_write_s;
  logic [DATA_WIDTH-1:0] rsp_rdata_r, rsp_rdata_s;
  logic [1:0]            rsp_resp_r, rsp_resp_s;
  logic                  awvalid_r, awvalid_s;
  logic                  wvalid_r, wvalid_s;
  logic                  bready_r, bready_s;
  logic                  arvalid_r, arvalid_s;
  logic                  rready_r, rready_s;
  logic                  rsp_valid_r, rsp_valid_s;
  logic                  cmd_ready_r, cmd_ready_s;
  logic                  misaligned_s;

`ifdef AXIL_MASTER_ALIGN_CHK_EN
  assign misaligned_s = (cmd_addr[1:0] != 2'b00);
`else
  assign misaligned_s = 1'b0;
`endif

  // The register already holds IDLE's value in reset; masking with ARESET keeps cmd_ready low only while reset is asserted.
  assign cmd_ready = cmd_ready_r & ~ARESET;
  assign AWVALID   = awvalid_r;
  assign WVALID    = wvalid_r;
  assign BREADY    = bready_r;
  assign ARVALID   = arvalid_r;
  assign RREADY    = rready_r;
  assign AWADDR    = addr_r;
  assign ARADDR    = addr_r;
  assign WDATA     = wdata_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = rsp_write_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_resp  = rsp_resp_r;

  // Next-state, captured fields and next values of every registered handshake output.
  always_comb begin
    state_s     = state_r;
    aw_done_s   = aw_done_r;
    w_done_s    = w_done_r;
    addr_s      = addr_r;
    wdata_s     = wdata_r;
    rsp_write_s = rsp_write_r;
    rsp_rdata_s = rsp_rdata_r;
    rsp_resp_s  = rsp_resp_r;
    case (state_r)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          addr_s      = cmd_addr;
          wdata_s     = cmd_wdata;
          rsp_write_s = cmd_write;
          aw_done_s   = 1'b0;
          w_done_s    = 1'b0;
          if (misaligned_s) begin
            state_s     = RSP;
            rsp_resp_s  = 2'b10;
            rsp_rdata_s = {DATA_WIDTH{1'b0}};
          end else if (cmd_write) begin
            state_s = WR_REQ;
          end else begin
            state_s = RD_REQ;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WR_REQ: begin
        aw_done_s = aw_done_r | (awvalid_r & AWREADY);
        w_done_s  = w_done_r | (wvalid_r & WREADY);
        if (aw_done_s && w_done_s) begin
          state_s = WR_RESP;
        end else begin
          state_s = WR_REQ;
        end
      end
      WR_RESP: begin
        if (BVALID && bready_r) begin
          state_s     = RSP;
          rsp_resp_s  = BRESP;
          rsp_rdata_s = {DATA_WIDTH{1'b0}};
          rsp_write_s = 1'b1;
        end else begin
          state_s = WR_RESP;
        end
      end
      RD_REQ: begin
        if (arvalid_r && ARREADY) begin
          state_s = RD_DATA;
        end else begin
          state_s = RD_REQ;
        end
      end
      RD_DATA: begin
        if (RVALID && rready_r) begin
          state_s     = RSP;
          rsp_rdata_s = RDATA;
          rsp_resp_s  = RRESP;
          rsp_write_s = 1'b0;
        end else begin
          state_s = RD_DATA;
        end
      end
      RSP: begin
        if (rsp_valid_r && rsp_ready) begin
          state_s = IDLE;
        end else begin
          state_s = RSP;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Outputs are registered from the next state so each VALID/READY lines up with its state.
    cmd_ready_s = (state_s == IDLE);
    awvalid_s   = (state_s == WR_REQ) && !aw_done_s;
    wvalid_s    = (state_s == WR_REQ) && !w_done_s;
    bready_s    = (state_s == WR_RESP);
    arvalid_s   = (state_s == RD_REQ);
    rready_s    = (state_s == RD_DATA);
    rsp_valid_s = (state_s == RSP);
  end

  // State and output registers with synchronous reset that drops any in-flight transfer.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_r     <= IDLE;
      aw_done_r   <= 1'b0;
      w_done_r    <= 1'b0;
      addr_r      <= {ADDR_WIDTH{1'b0}};
      wdata_r     <= {DATA_WIDTH{1'b0}};
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= {DATA_WIDTH{1'b0}};
      rsp_resp_r  <= 2'b00;
      awvalid_r   <= 1'b0;
      wvalid_r    <= 1'b0;
      bready_r    <= 1'b0;
      arvalid_r   <= 1'b0;
      rready_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      cmd_ready_r <= 1'b1;
    end else begin
      state_r     <= state_s;
      aw_done_r   <= aw_done_s;
      w_done_r    <= w_done_s;
      addr_r      <= addr_s;
      wdata_r     <= wdata_s;
      rsp_write_r <= rsp_write_s;
      rsp_rdata_r <= rsp_rdata_s;
      rsp_resp_r  <= rsp_resp_s;
      awvalid_r   <= awvalid_s;
      wvalid_r    <= wvalid_s;
      bready_r    <= bready_s;
      arvalid_r   <= arvalid_s;
      rready_r    <= rready_s;
      rsp_valid_r <= rsp_valid_s;
      cmd_ready_r <= cmd_ready_s;
    end
  end

endmodule
